// File: rtl/project_mux_pkg.sv
// Shared types and register map for the project multiplexer.
// Holds the sequencer state encoding, register offsets and CTRL/STATUS bit positions.
package project_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RESET = 2'd2,
    ST_LIVE  = 2'd3
  } state_t;

  localparam int SEL_W = 5;
  localparam int CNT_W = 8;

  localparam logic [1:0] CTRL_OFS   = 2'd0;
  localparam logic [1:0] STATUS_OFS = 2'd1;

  localparam int CTRL_SEL_LSB  = 0;
  localparam int CTRL_EN_BIT   = 8;
  localparam int STAT_SEL_LSB  = 0;
  localparam int STAT_BUSY_BIT = 8;
  localparam int STAT_LIVE_BIT = 9;
  localparam int STAT_ERR_BIT  = 10;

  function automatic logic is_busy(input state_t s);
    return (s == ST_DRAIN) || (s == ST_RESET);
  endfunction

endpackage

// File: rtl/project_mux_wb_regs.sv
// Wishbone slave for the project multiplexer: address decode, CTRL and sticky err storage,
// registered readback, and a one-cycle pulse for every accepted CTRL write.
module project_mux_wb_regs
  import project_mux_pkg::*;
#(
  parameter int NUM_PROJ = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stb,
  input  logic             i_cyc,
  input  logic             i_we,
  input  logic [3:0]       i_sel,
  input  logic [31:0]      i_adr,
  input  logic [31:0]      i_dat,
  output logic             o_ack,
  output logic [31:0]      o_dat,
  input  logic [SEL_W-1:0] i_cur_sel,
  input  logic             i_busy,
  input  logic             i_live,
  output logic             o_ctrl_wr,
  output logic [SEL_W-1:0] o_wr_sel,
  output logic             o_wr_en,
  output logic             o_ctrl_en
);

  localparam logic [SEL_W:0] NUM_SEL = (SEL_W + 1)'(NUM_PROJ);

  logic             r_ack;
  logic [31:0]      r_dat;
  logic [SEL_W-1:0] r_ctrl_sel;
  logic             r_ctrl_en;
  logic             r_err;

  logic             w_access;
  logic [1:0]       w_ofs;
  logic             w_ctrl_acc;
  logic [7:0]       w_lo;
  logic [7:0]       w_hi;
  logic             w_valid;
  logic [31:0]      w_rd;
  logic             w_unused;

  assign w_access   = i_stb & i_cyc & ~r_ack;
  assign w_ofs      = i_adr[3:2];
  assign w_ctrl_acc = w_access & i_we & (w_ofs == CTRL_OFS);

  // Lanes not selected keep their stored value, so the check runs on the merged word.
  assign w_lo     = i_sel[0] ? i_dat[7:0]  : {{(8 - SEL_W){1'b0}}, r_ctrl_sel};
  assign w_hi     = i_sel[1] ? i_dat[15:8] : {7'b0, r_ctrl_en};
  assign o_wr_sel = w_lo[SEL_W-1:0];
  assign o_wr_en  = w_hi[CTRL_EN_BIT-8];
  assign w_valid  = ~o_wr_en | ({1'b0, o_wr_sel} < NUM_SEL);
  assign o_ctrl_wr = w_ctrl_acc & w_valid;

  always_comb begin
    w_rd = '0;
    case (w_ofs)
      CTRL_OFS: begin
        w_rd[CTRL_SEL_LSB +: SEL_W] = r_ctrl_sel;
        w_rd[CTRL_EN_BIT]           = r_ctrl_en;
      end
      STATUS_OFS: begin
        w_rd[STAT_SEL_LSB +: SEL_W] = i_cur_sel;
        w_rd[STAT_BUSY_BIT]         = i_busy;
        w_rd[STAT_LIVE_BIT]         = i_live;
        w_rd[STAT_ERR_BIT]          = r_err;
      end
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_ctrl_sel <= '0;
      r_ctrl_en  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ack <= w_access;
      r_dat <= (w_access & ~i_we) ? w_rd : '0;
      if (w_ctrl_acc) begin
        if (w_valid) begin
          r_ctrl_sel <= o_wr_sel;
          r_ctrl_en  <= o_wr_en;
          r_err      <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign o_ack     = r_ack;
  assign o_dat     = r_dat;
  assign o_ctrl_en = r_ctrl_en;

  assign w_unused = ^{i_adr[31:4], i_adr[1:0], i_sel[3:2], i_dat[31:16],
                      w_lo[7:SEL_W], w_hi[7:1]};

endmodule

// File: rtl/project_mux.sv
// Multiplexes one of NUM_PROJ user projects onto a shared pad bus, sequencing every
// switch through a tristated drain phase and a held-reset phase before going live.
module project_mux
  import project_mux_pkg::*;
#(
  parameter int NUM_PROJ  = 8,
  parameter int IO_W      = 38,
  parameter int GUARD_CYC = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic [31:0]              wbs_dat_o,
  output logic                     wbs_ack_o,
  input  logic [NUM_PROJ*IO_W-1:0] proj_io_out_i,
  input  logic [NUM_PROJ*IO_W-1:0] proj_io_oeb_i,
  output logic [NUM_PROJ-1:0]      active_o,
  output logic [NUM_PROJ-1:0]      proj_rst_no,
  output logic [IO_W-1:0]          io_out,
  output logic [IO_W-1:0]          io_oeb
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GUARD_CYC - 1);

  logic [1:0]          r_rst_sync;
  logic                w_rst_n;

  state_t              r_state;
  state_t              w_state_next;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    w_sel_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;

  logic                w_ctrl_wr;
  logic [SEL_W-1:0]    w_wr_sel;
  logic                w_wr_en;
  logic                w_ctrl_en;

  logic [NUM_PROJ-1:0] w_onehot_next;
  logic [IO_W-1:0]     w_mux_out;
  logic [IO_W-1:0]     w_mux_oeb;

  logic [NUM_PROJ-1:0] r_active;
  logic [NUM_PROJ-1:0] r_proj_rst_n;
  logic [IO_W-1:0]     r_io_out;
  logic [IO_W-1:0]     r_io_oeb;

  // Reset asserts immediately but releases two clocks after wb_rst_ni rises.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  project_mux_wb_regs #(
    .NUM_PROJ (NUM_PROJ)
  ) u_regs (
    .i_clk     (wb_clk_i),
    .i_rst_n   (w_rst_n),
    .i_stb     (wbs_stb_i),
    .i_cyc     (wbs_cyc_i),
    .i_we      (wbs_we_i),
    .i_sel     (wbs_sel_i),
    .i_adr     (wbs_adr_i),
    .i_dat     (wbs_dat_i),
    .o_ack     (wbs_ack_o),
    .o_dat     (wbs_dat_o),
    .i_cur_sel (r_sel),
    .i_busy    (is_busy(r_state)),
    .i_live    (r_state == ST_LIVE),
    .o_ctrl_wr (w_ctrl_wr),
    .o_wr_sel  (w_wr_sel),
    .o_wr_en   (w_wr_en),
    .o_ctrl_en (w_ctrl_en)
  );

  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_cnt_next   = r_cnt;
    if (w_ctrl_wr && w_wr_en && !(r_state == ST_LIVE && w_wr_sel == r_sel)) begin
      w_state_next = ST_DRAIN;
      w_sel_next   = w_wr_sel;
      w_cnt_next   = CNT_LOAD;
    end else if (w_ctrl_wr && !w_wr_en) begin
      w_state_next = ST_DRAIN;
      w_cnt_next   = CNT_LOAD;
    end else begin
      case (r_state)
        ST_DRAIN: begin
          if (r_cnt == '0) begin
            w_state_next = w_ctrl_en ? ST_RESET : ST_IDLE;
            w_cnt_next   = w_ctrl_en ? CNT_LOAD : '0;
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
        ST_RESET: begin
          if (r_cnt == '0) w_state_next = ST_LIVE;
          else             w_cnt_next   = r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_PROJ; gi++) begin : g_onehot
    assign w_onehot_next[gi] = (w_sel_next == SEL_W'(gi));
  end

  always_comb begin
    w_mux_out = '0;
    w_mux_oeb = '1;
    for (int k = 0; k < NUM_PROJ; k++) begin
      if (w_sel_next == SEL_W'(k)) begin
        w_mux_out = proj_io_out_i[k*IO_W +: IO_W];
        w_mux_oeb = proj_io_oeb_i[k*IO_W +: IO_W];
      end
    end
  end

  // Outputs follow the next state so pads tristate on the same edge a switch is accepted.
  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_active     <= '0;
      r_proj_rst_n <= '0;
      r_io_out     <= '0;
      r_io_oeb     <= '1;
    end else begin
      r_active     <= (w_state_next == ST_RESET || w_state_next == ST_LIVE) ? w_onehot_next : '0;
      r_proj_rst_n <= (w_state_next == ST_LIVE) ? w_onehot_next : '0;
      r_io_out     <= (w_state_next == ST_LIVE) ? w_mux_out : '0;
      r_io_oeb     <= (w_state_next == ST_LIVE) ? w_mux_oeb : '1;
    end
  end

  assign active_o    = r_active;
  assign proj_rst_no = r_proj_rst_n;
  assign io_out      = r_io_out;
  assign io_oeb      = r_io_oeb;

endmodule

// File: tb/tb_project_mux.sv
// Directed bench for project_mux: switch sequencing, pad muxing, register access and reset abort.
module tb_project_mux;

  localparam int NP  = 8;
  localparam int IOW = 38;

  localparam logic [IOW-1:0] ALL1 = 38'h3F_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stb, cyc, we;
  logic [3:0]        sel;
  logic [31:0]       adr, dat_i, dat_o;
  logic              ack;
  logic [NP*IOW-1:0] proj_out, proj_oeb;
  logic [NP-1:0]     active, proj_rst_n;
  logic [IOW-1:0]    io_out, io_oeb;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd;

  project_mux #(.NUM_PROJ(NP), .IO_W(IOW), .GUARD_CYC(16)) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (dat_i),
    .wbs_dat_o     (dat_o),
    .wbs_ack_o     (ack),
    .proj_io_out_i (proj_out),
    .proj_io_oeb_i (proj_oeb),
    .active_o      (active),
    .proj_rst_no   (proj_rst_n),
    .io_out        (io_out),
    .io_oeb        (io_oeb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] q);
    logic got;
    got = 1'b0;
    q   = '0;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        q   = dat_o;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk(w ? "wr_ack" : "rd_ack", {63'b0, got}, 64'd1);
    if (w) $display("wr adr=%h sel=%h dat=%h ack=%0d", a, s, d, got);
    else   $display("rd adr=%h dat=%h ack=%0d", a, q, got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    sel = '0; adr = '0; dat_i = '0;
    for (int k = 0; k < NP; k++) begin
      proj_out[k*IOW +: IOW] = {6'(k + 1), 32'hC0DE_0000 + 32'(k)};
      proj_oeb[k*IOW +: IOW] = {6'h2A, 32'h0000_F000 + 32'(k)};
    end

    // reset values while held
    tick(2);
    chk("rst_oeb", io_oeb, ALL1);
    chk("rst_out", io_out, 0);
    chk("rst_active", active, 0);
    chk("rst_projrst", proj_rst_n, 0);
    chk("rst_ack", ack, 0);
    rst_n = 1'b1;
    tick(3);

    wb_xfer(0, 32'h4, 4'hF, 0, rd);
    chk("status_after_rst", rd, 32'h000);

    // select project 3
    wb_xfer(1, 32'h0, 4'h3, 32'h103, rd);
    chk("sel3_oeb", io_oeb, ALL1);
    chk("sel3_active0", active, 0);
    tick(15);
    chk("drain_end_active", active, 0);
    tick(1);
    chk("reset_active", active, 8'h08);
    chk("reset_projrst", proj_rst_n, 0);
    chk("reset_oeb", io_oeb, ALL1);
    tick(15);
    chk("reset_end_projrst", proj_rst_n, 0);
    tick(1);
    chk("live_projrst", proj_rst_n, 8'h08);
    chk("live_active", active, 8'h08);
    chk("live_out3", io_out, 38'h4_C0DE_0003);
    chk("live_oeb3", io_oeb, 38'h2A_0000_F003);
    wb_xfer(0, 32'h4, 4'hF, 0, rd);
    chk("status_live3", rd, 32'h203);

    // pad path has one cycle of latency
    proj_out[3*IOW +: IOW] = 38'h15_5555_5555;
    #1;
    chk("out_before_edge", io_out, 38'h4_C0DE_0003);
    tick(1);
    chk("out_after_edge", io_out, 38'h15_5555_5555);

    // switch to project 5
    wb_xfer(1, 32'h0, 4'h3, 32'h105, rd);
    chk("sw5_oeb", io_oeb, ALL1);
    chk("sw5_projrst", proj_rst_n, 0);
    chk("sw5_out", io_out, 0);
    tick(31);
    chk("sw5_active", active, 8'h20);
    chk("sw5_reset_projrst", proj_rst_n, 0);
    tick(1);
    chk("sw5_live_projrst", proj_rst_n, 8'h20);
    chk("sw5_out5", io_out, 38'h6_C0DE_0005);

    // out-of-range select
    wb_xfer(1, 32'h0, 4'h3, 32'h10A, rd);
    wb_xfer(0, 32'h4, 4'hF, 0, rd);
    chk("err_status", rd, 32'h605);
    wb_xfer(0, 32'h0, 4'hF, 0, rd);
    chk("err_ctrl_kept", rd, 32'h105);
    chk("err_active_kept", active, 8'h20);

    // valid write clears err, then restart drain at cycle 10
    wb_xfer(1, 32'h0, 4'h3, 32'h101, rd);
    wb_xfer(0, 32'h4, 4'hF, 0, rd);
    chk("clr_err_status", rd, 32'h101);
    wb_xfer(0, 32'h0, 4'hF, 0, rd);
    chk("ctrl_101", rd, 32'h101);
    tick(6);
    wb_xfer(1, 32'h0, 4'h3, 32'h102, rd);
    tick(6);
    chk("restart_active", active, 0);
    tick(25);
    chk("restart_reset_active", active, 8'h04);
    chk("restart_reset_projrst", proj_rst_n, 0);
    tick(1);
    chk("restart_live_projrst", proj_rst_n, 8'h04);
    chk("restart_live_active", active, 8'h04);

    // disable returns to idle
    wb_xfer(1, 32'h0, 4'h3, 32'h000, rd);
    chk("dis_active", active, 0);
    chk("dis_oeb", io_oeb, ALL1);
    tick(20);
    wb_xfer(0, 32'h4, 4'hF, 0, rd);
    chk("dis_status_idle", rd, 32'h002);
    chk("idle_active", active, 0);

    // byte lanes
    wb_xfer(1, 32'h0, 4'h1, 32'h0000_0105, rd);
    wb_xfer(0, 32'h0, 4'hF, 0, rd);
    chk("lane0_ctrl", rd, 32'h005);
    wb_xfer(1, 32'h0, 4'h2, 32'h0000_01FF, rd);
    wb_xfer(0, 32'h0, 4'hF, 0, rd);
    chk("lane1_ctrl", rd, 32'h105);
    wb_xfer(0, 32'h8, 4'hF, 0, rd);
    chk("unmapped_rd", rd, 32'h0);
    wb_xfer(1, 32'hC, 4'hF, 32'hFFFF_FFFF, rd);
    wb_xfer(0, 32'h0, 4'hF, 0, rd);
    chk("unmapped_wr_ignored", rd, 32'h105);

    // reset during RESET phase with strobe held
    tick(16);
    chk("pre_abort_active", active, 8'h20);
    chk("pre_abort_projrst", proj_rst_n, 0);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h4; sel = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("abort_active", active, 0);
    chk("abort_projrst", proj_rst_n, 0);
    chk("abort_oeb", io_oeb, ALL1);
    chk("abort_out", io_out, 0);
    chk("abort_dat", dat_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("abort_no_ack", ack, 0);
    end
    stb = 1'b0; cyc = 1'b0;
    rst_n = 1'b1;
    tick(3);
    wb_xfer(0, 32'h4, 4'hF, 0, rd);
    chk("post_abort_status", rd, 32'h000);
    wb_xfer(0, 32'h0, 4'hF, 0, rd);
    chk("post_abort_ctrl", rd, 32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
